// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction and PC+2 for decode,
// with hazard stall, control-transfer flush, validity/error tracking and HALT flag.
module if_id_reg #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [15:0] InstrIn,
    input  logic [15:0] PCAdd2In,
    input  logic        InstrErrIn,
    output logic [15:0] InstrOut,
    output logic [15:0] PCAdd2Out,
    output logic        ValidOut,
    output logic        HaltOut,
    output logic        rstOut,
    output logic        errOut,
    output logic [15:0] FlushCnt
);

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPC_LSB  = 11;
    localparam int unsigned OPC_W    = 5;

    logic errQ;
    logic [OPC_W-1:0] opcode;

    // Reset forward is unconditional; stage state follows rst > Flush > Stall > load.
    always_ff @(posedge clk) begin
        rstOut <= rst;
        if (rst) begin
            InstrOut  <= NOP_INSTR;
            PCAdd2Out <= '0;
            ValidOut  <= 1'b0;
            errQ      <= 1'b0;
            FlushCnt  <= '0;
        end else if (Flush) begin
            InstrOut  <= NOP_INSTR;
            PCAdd2Out <= PCAdd2In;
            ValidOut  <= 1'b0;
            errQ      <= 1'b0;
            // Only squashing a real instruction counts; back-to-back flushes hit a bubble.
            if (ValidOut) begin
                FlushCnt <= FlushCnt + INSTR_W'(1);
            end
        end else if (!Stall) begin
            InstrOut  <= InstrIn;
            PCAdd2Out <= PCAdd2In;
            ValidOut  <= 1'b1;
            errQ      <= InstrErrIn;
        end
    end

    assign opcode  = InstrOut[OPC_LSB +: OPC_W];
    assign HaltOut = ValidOut & (opcode == HALT_OPC);
    assign errOut  = errQ & ~rstOut;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed, table-driven bench for if_id_reg with hand-computed expected values.
module tb_if_id_reg;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        Flush;
    logic [15:0] InstrIn;
    logic [15:0] PCAdd2In;
    logic        InstrErrIn;
    logic [15:0] InstrOut;
    logic [15:0] PCAdd2Out;
    logic        ValidOut;
    logic        HaltOut;
    logic        rstOut;
    logic        errOut;
    logic [15:0] FlushCnt;

    int checks = 0;
    int errors = 0;

    if_id_reg dut (
        .clk       (clk),
        .rst       (rst),
        .Stall     (Stall),
        .Flush     (Flush),
        .InstrIn   (InstrIn),
        .PCAdd2In  (PCAdd2In),
        .InstrErrIn(InstrErrIn),
        .InstrOut  (InstrOut),
        .PCAdd2Out (PCAdd2Out),
        .ValidOut  (ValidOut),
        .HaltOut   (HaltOut),
        .rstOut    (rstOut),
        .errOut    (errOut),
        .FlushCnt  (FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        err;
        logic [15:0] eInstr;
        logic [15:0] ePc;
        logic        eValid;
        logic        eHalt;
        logic        eRstOut;
        logic        eErr;
        logic [15:0] eCnt;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mkVec(
        input logic r, input logic s, input logic f,
        input logic [15:0] i, input logic [15:0] p, input logic e,
        input logic [15:0] ei, input logic [15:0] ep, input logic ev,
        input logic eh, input logic er, input logic ee, input logic [15:0] ec);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.instr = i; v.pc = p; v.err = e;
        v.eInstr = ei; v.ePc = ep; v.eValid = ev; v.eHalt = eh;
        v.eRstOut = er; v.eErr = ee; v.eCnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic [15:0] i, input logic [15:0] p, input logic e);
        rst = r; Stall = s; Flush = f; InstrIn = i; PCAdd2In = p; InstrErrIn = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chkAll(input int idx, input vec_t v);
        chk("InstrOut",  idx, InstrOut,          v.eInstr);
        chk("PCAdd2Out", idx, PCAdd2Out,         v.ePc);
        chk("ValidOut",  idx, 16'(ValidOut),     16'(v.eValid));
        chk("HaltOut",   idx, 16'(HaltOut),      16'(v.eHalt));
        chk("rstOut",    idx, 16'(rstOut),       16'(v.eRstOut));
        chk("errOut",    idx, 16'(errOut),       16'(v.eErr));
        chk("FlushCnt",  idx, FlushCnt,          v.eCnt);
    endtask

    initial begin
        //                r  s  f  instr     pc       e    eInstr    ePc      V  H  R  E  eCnt
        vecs[0]  = mkVec(1, 0, 0, 16'h1234, 16'h0022, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 16'd0);
        vecs[1]  = mkVec(1, 0, 0, 16'h1234, 16'h0022, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 16'd0);
        vecs[2]  = mkVec(0, 0, 0, 16'hC0A5, 16'h0002, 0, 16'hC0A5, 16'h0002, 1, 0, 0, 0, 16'd0);
        vecs[3]  = mkVec(0, 1, 0, 16'hFFFF, 16'h0004, 0, 16'hC0A5, 16'h0002, 1, 0, 0, 0, 16'd0);
        vecs[4]  = mkVec(0, 1, 0, 16'hFFFF, 16'h0004, 0, 16'hC0A5, 16'h0002, 1, 0, 0, 0, 16'd0);
        vecs[5]  = mkVec(0, 1, 0, 16'hFFFF, 16'h0004, 0, 16'hC0A5, 16'h0002, 1, 0, 0, 0, 16'd0);
        vecs[6]  = mkVec(0, 0, 0, 16'hFFFF, 16'h0004, 0, 16'hFFFF, 16'h0004, 1, 0, 0, 0, 16'd0);
        vecs[7]  = mkVec(0, 0, 0, 16'h4321, 16'h0006, 0, 16'h4321, 16'h0006, 1, 0, 0, 0, 16'd0);
        vecs[8]  = mkVec(0, 1, 1, 16'h5555, 16'h0010, 0, 16'h0800, 16'h0010, 0, 0, 0, 0, 16'd1);
        vecs[9]  = mkVec(0, 0, 1, 16'h5555, 16'h0012, 0, 16'h0800, 16'h0012, 0, 0, 0, 0, 16'd1);
        vecs[10] = mkVec(0, 0, 0, 16'h1111, 16'h0014, 1, 16'h1111, 16'h0014, 1, 0, 0, 1, 16'd1);
        vecs[11] = mkVec(0, 1, 0, 16'h2222, 16'h0016, 0, 16'h1111, 16'h0014, 1, 0, 0, 1, 16'd1);
        vecs[12] = mkVec(0, 1, 0, 16'h2222, 16'h0016, 0, 16'h1111, 16'h0014, 1, 0, 0, 1, 16'd1);
        vecs[13] = mkVec(0, 0, 1, 16'h2222, 16'h0016, 0, 16'h0800, 16'h0016, 0, 0, 0, 0, 16'd2);
        vecs[14] = mkVec(0, 0, 0, 16'h0000, 16'h0018, 0, 16'h0000, 16'h0018, 1, 1, 0, 0, 16'd2);
        vecs[15] = mkVec(0, 1, 0, 16'h0800, 16'h001A, 0, 16'h0000, 16'h0018, 1, 1, 0, 0, 16'd2);
        vecs[16] = mkVec(0, 0, 1, 16'h0800, 16'h001A, 0, 16'h0800, 16'h001A, 0, 0, 0, 0, 16'd3);
        vecs[17] = mkVec(0, 0, 0, 16'h0005, 16'h001C, 0, 16'h0005, 16'h001C, 1, 1, 0, 0, 16'd3);
        vecs[18] = mkVec(1, 1, 0, 16'h7777, 16'h001E, 0, 16'h0800, 16'h0000, 0, 0, 1, 0, 16'd0);
        vecs[19] = mkVec(1, 0, 0, 16'h7777, 16'h001E, 1, 16'h0800, 16'h0000, 0, 0, 1, 0, 16'd0);
        vecs[20] = mkVec(0, 1, 0, 16'h7777, 16'h001E, 1, 16'h0800, 16'h0000, 0, 0, 0, 0, 16'd0);
        vecs[21] = mkVec(0, 0, 0, 16'h0800, 16'h0002, 1, 16'h0800, 16'h0002, 1, 0, 0, 1, 16'd0);
        vecs[22] = mkVec(1, 0, 1, 16'h0000, 16'h0030, 1, 16'h0800, 16'h0000, 0, 0, 1, 0, 16'd0);
        vecs[23] = mkVec(0, 0, 1, 16'h0000, 16'h0004, 0, 16'h0800, 16'h0004, 0, 0, 0, 0, 16'd0);

        rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        InstrIn = 16'h1234; PCAdd2In = 16'h0000; InstrErrIn = 1'b0;
        @(negedge clk);

        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].rst, vecs[k].stall, vecs[k].flush,
                  vecs[k].instr, vecs[k].pc, vecs[k].err);
            chkAll(k, vecs[k]);
        end

        // Counter wrap: preset the counter near the top while the stage is stalled.
        drive(0, 0, 0, 16'h1234, 16'h0040, 0);
        chk("wrapLoadValid", 100, 16'(ValidOut), 16'd1);
        Stall = 1'b1;
        force dut.FlushCnt = 16'hFFFE;
        #1;
        release dut.FlushCnt;
        drive(0, 1, 0, 16'h1234, 16'h0040, 0);
        chk("wrapPreset", 101, FlushCnt, 16'hFFFE);
        drive(0, 0, 1, 16'h1234, 16'h0042, 0);
        chk("wrapFFFF", 102, FlushCnt, 16'hFFFF);
        drive(0, 0, 0, 16'h2345, 16'h0044, 0);
        chk("wrapValid", 103, 16'(ValidOut), 16'd1);
        drive(0, 0, 1, 16'h2345, 16'h0046, 0);
        chk("wrapZero", 104, FlushCnt, 16'h0000);
        chk("wrapBubble", 105, InstrOut, 16'h0800);
        drive(0, 0, 1, 16'h2345, 16'h0048, 0);
        chk("wrapHold", 106, FlushCnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between instruction fetch and decode. It holds the fetched instruction and the PC+2 value for the decode stage.
- Supports a hazard stall, which holds the current contents, and a control-transfer flush, which inserts a bubble.
- Tracks instruction validity and fetch errors, and flags a HALT instruction to decode.
- Its outputs feed the decode logic that drives the ID/EX stage register.

Parameters:
NOP_INSTR, 16'h0800, encoding inserted on reset/flush (opcode 00001, all other bits 0)
HALT_OPC, 5'b00000, opcode recognised as HALT

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
Stall  in  1  hold all stage contents this cycle (load-use/structural hazard)
Flush  in  1  squash stage contents (taken branch/jump resolved downstream)
InstrIn  in  16  instruction from fetch
PCAdd2In  in  16  PC+2 of fetched instruction
InstrErrIn  in  1  fetch-side error for this instruction
InstrOut  out  16  registered instruction to decode
PCAdd2Out  out  16  registered PC+2
ValidOut  out  1  1 = InstrOut is a real fetched instruction, 0 = bubble
HaltOut  out  1  combinational: ValidOut & (InstrOut[15:11]==HALT_OPC)
rstOut  out  1  registered copy of rst, forwarded down the pipe
errOut  out  1  registered error, masked by rstOut
FlushCnt  out  16  count of flushes that squashed a valid instruction (performance counter)

Behaviour:
- All state is in flops updated on posedge clk. There is no asynchronous path from inputs to registered outputs. HaltOut is decoded from registered state only.
- Priority each cycle: rst > Flush > Stall > normal load.
- rst=1 sets:
  - InstrOut=NOP_INSTR, PCAdd2Out=0, ValidOut=0
  - error flop=0, FlushCnt=0
  - rstOut=1 on the following cycle
- rstOut: loads rst every cycle unconditionally. Stall and Flush do not affect it.
- Flush=1 (rst=0), regardless of Stall:
  - InstrOut=NOP_INSTR, ValidOut=0, error flop=0
  - PCAdd2Out loads PCAdd2In, so bubble tracking keeps a PC value
  - FlushCnt increments only if ValidOut was 1 before the edge
- Stall=1 (rst=0, Flush=0): all registers hold. FlushCnt holds.
- Normal (rst=0, Flush=0, Stall=0): InstrOut<=InstrIn, PCAdd2Out<=PCAdd2In, ValidOut<=1, error flop<=InstrErrIn.
- errOut = error flop & ~rstOut. An error stays visible for as long as the stage is stalled.
- FlushCnt wraps from 16'hFFFF to 0 with no saturation.
- Latency: one cycle from In to Out when not stalled.
- Reset mid-stall or mid-flush: reset wins and the stage is empty on the next cycle.
- Stall sustained N cycles: outputs stay bit-identical for N cycles. The first unstalled edge loads the current InstrIn.
- Back-to-back flushes: each edge with Flush produces a bubble. FlushCnt increments only on the first, because ValidOut is already 0 afterwards.
- HALT under stall: HaltOut stays 1 while the stall is held. A flush clears it because ValidOut goes to 0.

Test Plan:
- Reset: hold rst 2 cycles with InstrIn=16'h1234 -> InstrOut=16'h0800, ValidOut=0, PCAdd2Out=0, FlushCnt=0, errOut=0. rstOut=1 the cycle after each rst cycle, 0 one cycle after rst drops.
- Load then stall: InstrIn=16'hC0A5, PCAdd2In=16'h0002, edge -> InstrOut=16'hC0A5, ValidOut=1. Then Stall=1 for 3 cycles while InstrIn=16'hFFFF -> outputs unchanged. On release, the next edge loads 16'hFFFF.
- Flush over stall: valid 16'h4321 latched, then Stall=1 and Flush=1 with PCAdd2In=16'h0010 -> InstrOut=16'h0800, ValidOut=0, PCAdd2Out=16'h0010, FlushCnt=1. A second consecutive flush leaves FlushCnt=1.
- Error path: InstrErrIn=1 with a normal load -> errOut=1. Stall 2 cycles -> errOut stays 1. Flush -> errOut=0. InstrErrIn=1 in the cycle before reset release -> errOut=0 while rstOut=1.
- HALT decode: InstrIn=16'h0000 loaded -> HaltOut=1. Stall -> HaltOut stays 1. Flush -> HaltOut=0. After reset, InstrOut=16'h0800 -> HaltOut=0.
- Counter wrap: preload by 65535 valid-then-flush pairs (or force) -> FlushCnt=16'hFFFF. One more valid flush -> FlushCnt=16'h0000.
